// File: rtl/ldburst.sv
// Load-side burst sequencer: issues a run of strided reads across the 12 data-memory banks
// and permutes each returned 12-lane word through a per-function lane-select table.
module ldburst #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int NBANK  = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [ADDR_W-1:0]       i_base,
  input  logic [ADDR_W-1:0]       i_stride,
  input  logic [4:0]              i_count,
  input  logic [3:0]              i_func,
  input  logic                    i_stall,
  output logic                    o_busy,
  output logic [NBANK-1:0]        o_dmemre,
  output logic [ADDR_W-1:0]       o_dmemad,
  input  logic [NBANK*DATA_W-1:0] i_dmemrd,
  output logic [NBANK*DATA_W-1:0] o_topearray,
  output logic                    o_valid,
  input  logic                    i_exwe,
  input  logic                    i_exre,
  input  logic [5:0]              i_exa,
  input  logic [DATA_W-1:0]       i_exwd,
  output logic [DATA_W-1:0]       o_exrd
);

  localparam int NENT  = 16;
  localparam int SEL_W = 4;
  localparam int NSEL  = 1 << SEL_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   stride_q, stride_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                drain_q, drain_d;
  logic                load;
  logic                issue;

  logic [DATA_W-1:0]   tbl_q [NENT][4];
  logic [DATA_W-1:0]   exrd_q;
  logic [3*DATA_W-1:0] sel_flat;
  logic [SEL_W-1:0]    snap_sel_q [NBANK];
  logic [NBANK-1:0]    snap_map_q;

  logic                      vld1_q, valid_q;
  logic [NBANK*DATA_W-1:0]   top_q, perm;
  logic [DATA_W-1:0]         bank [NSEL];
  logic [NSEL-1:0]           map_ext;

  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
    load     = 1'b0;
    issue    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start && i_count != 5'd0) begin
          load     = 1'b1;
          addr_d   = i_base;
          stride_d = i_stride;
          cnt_d    = i_count;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (!i_stall) begin
          issue  = 1'b1;
          addr_d = addr_q + stride_q;
          cnt_d  = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_d = DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        // Two cycles let the last beat pass through the bank read and the output register.
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = IDLE;
          drain_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      cnt_q    <= '0;
      drain_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
    end
  end

  assign o_busy   = (state_q != IDLE);
  assign o_dmemre = issue ? snap_map_q : '0;
  assign o_dmemad = issue ? addr_q : '0;

  // NOTE: the table is built from flops rather than RAM, so it can be cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int e = 0; e < NENT; e++)
        for (int w = 0; w < 4; w++)
          tbl_q[e][w] <= '0;
      exrd_q <= '0;
    end else begin
      if (i_exwe)
        tbl_q[i_exa[5:2]][i_exa[1:0]] <= (i_exa[1:0] == 2'd3)
                                         ? {{(DATA_W-NBANK){1'b0}}, i_exwd[NBANK-1:0]}
                                         : i_exwd;
      if (i_exre)
        exrd_q <= tbl_q[i_exa[5:2]][i_exa[1:0]];
    end
  end

  assign o_exrd = exrd_q;

  assign sel_flat = {tbl_q[i_func][2'd2], tbl_q[i_func][2'd1], tbl_q[i_func][2'd0]};

  // The burst works from a private copy so table writes mid-burst cannot disturb it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NBANK; i++) snap_sel_q[i] <= '0;
      snap_map_q <= '0;
    end else if (load) begin
      for (int i = 0; i < NBANK; i++) snap_sel_q[i] <= sel_flat[i*SEL_W +: SEL_W];
      snap_map_q <= tbl_q[i_func][2'd3][NBANK-1:0];
    end
  end

  // Selector codes 12..15 land on zero banks with zero map bits, so they yield 0.
  always_comb begin
    map_ext = {{(NSEL-NBANK){1'b0}}, snap_map_q};
    for (int k = 0; k < NSEL; k++) bank[k] = '0;
    for (int k = 0; k < NBANK; k++) bank[k] = i_dmemrd[k*DATA_W +: DATA_W];
    perm = '0;
    for (int i = 0; i < NBANK; i++)
      if (map_ext[snap_sel_q[i]]) perm[i*DATA_W +: DATA_W] = bank[snap_sel_q[i]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld1_q  <= 1'b0;
      valid_q <= 1'b0;
      top_q   <= '0;
    end else begin
      vld1_q  <= issue;
      valid_q <= vld1_q;
      if (vld1_q) top_q <= perm;
    end
  end

  assign o_topearray = top_q;
  assign o_valid     = valid_q;

endmodule

// File: tb/tb_ldburst.sv
// Directed self-checking bench for ldburst with a behavioural 12-bank memory returning {bank,addr}.
module tb_ldburst;

  localparam logic [47:0] SEL_ID  = 48'hBA98_7654_3210;
  localparam logic [47:0] SEL_REV = 48'h0123_4567_89AB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_start;
  logic [9:0]   i_base, i_stride;
  logic [4:0]   i_count;
  logic [3:0]   i_func;
  logic         i_stall;
  logic         o_busy;
  logic [11:0]  o_dmemre;
  logic [9:0]   o_dmemad;
  logic [191:0] i_dmemrd = '0;
  logic [191:0] o_topearray;
  logic         o_valid;
  logic         i_exwe, i_exre;
  logic [5:0]   i_exa;
  logic [15:0]  i_exwd;
  logic [15:0]  o_exrd;

  int tests = 0;
  int fails = 0;
  logic [9:0] iss_rec [32];

  ldburst dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_base(i_base), .i_stride(i_stride),
    .i_count(i_count), .i_func(i_func), .i_stall(i_stall), .o_busy(o_busy),
    .o_dmemre(o_dmemre), .o_dmemad(o_dmemad), .i_dmemrd(i_dmemrd),
    .o_topearray(o_topearray), .o_valid(o_valid), .i_exwe(i_exwe), .i_exre(i_exre),
    .i_exa(i_exa), .i_exwd(i_exwd), .o_exrd(o_exrd)
  );

  always #5 clk = ~clk;

  // Unread banks return a marker that must never reach the PE array.
  always @(posedge clk)
    for (int k = 0; k < 12; k++)
      i_dmemrd[k*16 +: 16] <= o_dmemre[k] ? {2'b00, 4'(k), o_dmemad} : 16'hDEAD;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [191:0] exp_word(input logic [47:0] sel, input logic [11:0] map,
                                             input logic [9:0] addr);
    logic [191:0] w;
    logic [3:0] s;
    w = '0;
    for (int i = 0; i < 12; i++) begin
      s = sel[i*4 +: 4];
      if (s < 4'd12 && map[s]) w[i*16 +: 16] = {2'b00, s, addr};
    end
    return w;
  endfunction

  task automatic tbl_wr(input logic [5:0] a, input logic [15:0] d);
    i_exwe = 1'b1; i_exa = a; i_exwd = d;
    tick();
    i_exwe = 1'b0;
  endtask

  task automatic tbl_rd(input string tag, input logic [5:0] a, input logic [15:0] exp);
    i_exre = 1'b1; i_exa = a;
    tick();
    i_exre = 1'b0;
    check(tag, o_exrd, exp);
  endtask

  task automatic load_entry(input logic [3:0] e, input logic [47:0] sel, input logic [15:0] map);
    tbl_wr({e, 2'd0}, sel[15:0]);
    tbl_wr({e, 2'd1}, sel[31:16]);
    tbl_wr({e, 2'd2}, sel[47:32]);
    tbl_wr({e, 2'd3}, map);
  endtask

  // Drives one burst and checks every cycle against the issue/latency rules; at mid_cyc it
  // rewrites word 0 of the active entry and re-pulses start, neither of which may matter.
  task automatic run_burst(input string tag, input logic [9:0] base, input logic [9:0] stride,
                           input int count, input logic [3:0] func, input logic [47:0] sel,
                           input logic [11:0] map, input int stall_from, input int stall_len,
                           input int mid_cyc);
    logic [9:0] a;
    logic       st, iss;
    logic       iss_v [64];
    logic [9:0] iss_a [64];
    int issued, last, nvalid;
    check({tag, "_idle"}, o_busy, 1'b0);
    i_base = base; i_stride = stride; i_count = 5'(count); i_func = func; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    a = base; issued = 0; last = -10; nvalid = 0;
    for (int cyc = 0; cyc < count + stall_len + 4; cyc++) begin
      st = (cyc >= stall_from) && (cyc < stall_from + stall_len);
      i_stall = st;
      if (cyc == mid_cyc) begin
        i_exwe = 1'b1; i_exa = {func, 2'd0}; i_exwd = 16'h0000;
        i_start = 1'b1; i_base = 10'h200; i_count = 5'd2;
      end
      #1;
      iss = (issued < count) && !st;
      check($sformatf("%s_re%0d", tag, cyc), o_dmemre, iss ? map : 12'h000);
      check($sformatf("%s_ad%0d", tag, cyc), o_dmemad, iss ? a : 10'h000);
      iss_v[cyc] = iss;
      iss_a[cyc] = a;
      if (iss) begin
        iss_rec[issued] = a;
        issued++;
        a = a + stride;
        last = cyc;
      end
      check($sformatf("%s_busy%0d", tag, cyc), o_busy, (issued < count) || (cyc <= last + 2));
      if (cyc >= 2 && iss_v[cyc-2]) begin
        nvalid++;
        check($sformatf("%s_v%0d", tag, cyc), o_valid, 1'b1);
        check($sformatf("%s_lanes%0d", tag, cyc), o_topearray, exp_word(sel, map, iss_a[cyc-2]));
      end else begin
        check($sformatf("%s_v%0d", tag, cyc), o_valid, 1'b0);
      end
      tick();
      i_exwe = 1'b0; i_start = 1'b0;
    end
    i_stall = 1'b0;
    check({tag, "_nvalid"}, nvalid, count);
    if (count > 0)
      check({tag, "_hold"}, o_topearray, exp_word(sel, map, iss_rec[count-1]));
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_base = '0; i_stride = '0; i_count = '0; i_func = '0;
    i_stall = 1'b0; i_exwe = 1'b0; i_exre = 1'b0; i_exa = '0; i_exwd = '0;
    tick(); tick();
    check("rst_busy", o_busy, 1'b0);
    check("rst_valid", o_valid, 1'b0);
    check("rst_re", o_dmemre, 12'h000);
    check("rst_ad", o_dmemad, 10'h000);
    check("rst_top", o_topearray, 192'h0);
    check("rst_exrd", o_exrd, 16'h0000);
    rst_n = 1'b1;
    tick();

    for (int w = 0; w < 64; w++) tbl_rd($sformatf("clr_w%0d", w), 6'(w), 16'h0000);

    load_entry(4'd3, SEL_ID, 16'hFFFF);
    tbl_rd("e3_map_mask", 6'd15, 16'h0FFF);
    tbl_rd("e3_sel0", 6'd12, 16'h3210);
    tick();
    check("exrd_hold", o_exrd, 16'h3210);

    tbl_wr(6'd29, 16'h1234);
    i_exwe = 1'b1; i_exre = 1'b1; i_exa = 6'd29; i_exwd = 16'h5678;
    tick();
    i_exwe = 1'b0; i_exre = 1'b0;
    check("rw_same_old", o_exrd, 16'h1234);
    tbl_rd("rw_same_new", 6'd29, 16'h5678);

    run_burst("b1", 10'h010, 10'd2, 4, 4'd3, SEL_ID, 12'hFFF, -1, 0, -1);
    check("b1_a0", iss_rec[0], 10'h010);
    check("b1_a3", iss_rec[3], 10'h016);

    run_burst("zero", 10'h050, 10'd1, 0, 4'd3, SEL_ID, 12'hFFF, -1, 0, -1);

    load_entry(4'd5, SEL_REV, 16'h00F0);
    run_burst("rev", 10'h020, 10'd1, 2, 4'd5, SEL_REV, 12'h0F0, -1, 0, -1);
    check("rev_lanes_hand", o_topearray,
          {64'h0, 16'h1021, 16'h1421, 16'h1821, 16'h1C21, 64'h0});

    run_burst("wrap", 10'h3FE, 10'd3, 3, 4'd3, SEL_ID, 12'hFFF, -1, 0, -1);
    check("wrap_a1", iss_rec[1], 10'h001);
    check("wrap_a2", iss_rec[2], 10'h004);

    run_burst("stall", 10'h040, 10'd4, 3, 4'd3, SEL_ID, 12'hFFF, 1, 2, -1);
    check("stall_a1", iss_rec[1], 10'h044);
    check("stall_a2", iss_rec[2], 10'h048);

    run_burst("mid", 10'h080, 10'd1, 5, 4'd3, SEL_ID, 12'hFFF, -1, 0, 2);
    tbl_rd("mid_wr_landed", 6'd12, 16'h0000);
    check("mid_idle", o_busy, 1'b0);

    tbl_rd("pre_rst_exrd", 6'd15, 16'h0FFF);
    i_base = 10'h100; i_stride = 10'd1; i_count = 5'd8; i_func = 4'd3; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick(); tick();
    check("mid_rst_running", o_busy, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_busy", o_busy, 1'b0);
    check("mrst_re", o_dmemre, 12'h000);
    check("mrst_ad", o_dmemad, 10'h000);
    check("mrst_top", o_topearray, 192'h0);
    check("mrst_valid", o_valid, 1'b0);
    check("mrst_exrd", o_exrd, 16'h0000);
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("mrst_quiet_v%0d", c), o_valid, 1'b0);
      check($sformatf("mrst_quiet_b%0d", c), o_busy, 1'b0);
    end
    tbl_rd("mrst_tbl_clr", 6'd15, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
